// File: rtl/rgb_to_ycbcr.sv
// ---------------------------------------------------------------------------
// rgb_to_ycbcr
//
// Purpose:
//   Converts a 24-bit RGB pixel stream to full-range BT.601 YCbCr.
//   - Three register stages: nine products, then three rounded sums, then
//     shift, chroma offset and clamp into the output register.
//   - Ready/valid backpressure: the whole pipe shifts or holds as one.
//   - Forwards the 36-bit control (frame-size) word.
//   - Tracks the output-side x/y position and pulses frame_end on the
//     last pixel of each frame.
//
// Parameters:
//   PIPE_STAGES  conversion latency in accepted cycles (only 3 is supported)
//   COEF_FRAC    fractional bits of the integer coefficients (8)
//
// Ports:
//   clk                clock
//   rst                synchronous active-high reset
//   video_in_data      {R[23:16], G[15:8], B[7:0]}
//   video_in_valid     input pixel valid
//   video_in_ready     input pixel accepted when valid & ready
//   video_out_data     {Y[23:16], Cb[15:8], Cr[7:0]}
//   video_out_valid    output pixel valid
//   video_out_ready    downstream accepts
//   control_in_data    width[35:20], height[19:4], [3:0] reserved
//   control_in_valid   control word strobe
//   control_out_data   forwarded control word
//   control_out_valid  forwarded strobe (1-cycle pulse)
//   frame_end          1-cycle pulse after the last pixel of a frame leaves
//   bypass             (only with RGB2YCC_BYPASS_EN) pass pixel unconverted
//
// Optional feature macro: RGB2YCC_BYPASS_EN
//   When defined, adds the bypass input. A pixel accepted with bypass = 1
//   leaves unchanged with the same latency as converted pixels.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rgb_to_ycbcr #(
  parameter int PIPE_STAGES = 3,
  parameter int COEF_FRAC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] video_in_data,
  input  logic        video_in_valid,
  output logic        video_in_ready,
  output logic [23:0] video_out_data,
  output logic        video_out_valid,
  input  logic        video_out_ready,
  input  logic [35:0] control_in_data,
  input  logic        control_in_valid,
  output logic [35:0] control_out_data,
  output logic        control_out_valid,
  output logic        frame_end
`ifdef RGB2YCC_BYPASS_EN
  ,
  input  logic        bypass
`endif
);

  // Sums need 19 signed bits at least; 20 leaves headroom for the rounding.
  localparam int SUM_W = 20;
  localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [SUM_W-1:0] MAX8  = SUM_W'(255);

  // Row-major: Y row, Cb row, Cr row; columns R, G, B.
  localparam logic signed [8:0] COEF [9] = '{
    9'sd77,   9'sd150,  9'sd29,
    -9'sd43,  -9'sd85,  9'sd128,
    9'sd128,  -9'sd107, -9'sd21
  };

  // Sign-extend a 17-bit product to the sum width.
  function automatic logic signed [SUM_W-1:0] sx(input logic signed [16:0] v);
    return {{(SUM_W-17){v[16]}}, v};
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline enable: the whole pipe moves when the output slot is free or
  // being taken. Bubbles are not collapsed, so latency is always fixed.
  // -------------------------------------------------------------------------
  logic                   en;
  logic [PIPE_STAGES-1:0] valid_pipe_reg;

  assign en              = ~valid_pipe_reg[PIPE_STAGES-1] | video_out_ready;
  assign video_in_ready  = en;
  assign video_out_valid = valid_pipe_reg[PIPE_STAGES-1];

  // The datapath below is built for exactly three register stages; the
  // valid shift register mirrors that depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_pipe_reg <= '0;
    end else if (en) begin
      valid_pipe_reg <= {valid_pipe_reg[PIPE_STAGES-2:0], video_in_valid};
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: nine products. Operands are widened to 17 bits so the signed
  // multiply is evaluated at the product width.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_mul
      logic signed [16:0] coef_ext;
      logic signed [16:0] pix_ext;
      logic signed [16:0] prod_reg;

      assign coef_ext = {{8{COEF[gi][8]}}, COEF[gi]};
      assign pix_ext  = {9'd0, video_in_data[23-8*(gi%3) -: 8]};

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg <= '0;
        end else if (en) begin
          prod_reg <= coef_ext * pix_ext;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage 2: three rounded sums.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sum
      logic signed [SUM_W-1:0] sum_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_reg <= '0;
        end else if (en) begin
          sum_reg <= sx(g_mul[3*gi].prod_reg) + sx(g_mul[3*gi+1].prod_reg)
                   + sx(g_mul[3*gi+2].prod_reg) + ROUND;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage 3 (combinational part): arithmetic shift, chroma offset, then
  // clamp. The clamp comes after the offset so Cb/Cr saturate at 0 and 255.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 3; gi++) begin : g_out
      localparam logic signed [SUM_W-1:0] OFFS = (gi == 0) ? SUM_W'(0) : SUM_W'(128);
      logic signed [SUM_W-1:0] scaled;
      logic [7:0]              pix;

      assign scaled = (g_sum[gi].sum_reg >>> COEF_FRAC) + OFFS;

      always_comb begin
        pix = scaled[7:0];
        if (scaled[SUM_W-1]) begin
          pix = 8'd0;
        end else if (scaled > MAX8) begin
          pix = 8'hFF;
        end
      end
    end
  endgenerate

  logic [23:0] conv_data;
  logic [23:0] out_data_reg;

  assign conv_data      = {g_out[0].pix, g_out[1].pix, g_out[2].pix};
  assign video_out_data = out_data_reg;

`ifdef RGB2YCC_BYPASS_EN
  // The raw pixel and its bypass tag travel beside the arithmetic stages.
  logic [1:0]  byp_flag_reg;
  logic [23:0] byp_data1_reg;
  logic [23:0] byp_data2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_flag_reg  <= '0;
      byp_data1_reg <= '0;
      byp_data2_reg <= '0;
    end else if (en) begin
      byp_flag_reg  <= {byp_flag_reg[0], bypass};
      byp_data1_reg <= video_in_data;
      byp_data2_reg <= byp_data1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
    end else if (en) begin
      out_data_reg <= byp_flag_reg[1] ? byp_data2_reg : conv_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
    end else if (en) begin
      out_data_reg <= conv_data;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Control word: latch frame size and forward the word one cycle later,
  // regardless of video stalls.
  // -------------------------------------------------------------------------
  logic [15:0] width_reg;
  logic [15:0] height_reg;
  logic [35:0] ctrl_data_reg;
  logic        ctrl_valid_reg;

  assign control_out_data  = ctrl_data_reg;
  assign control_out_valid = ctrl_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      width_reg      <= '0;
      height_reg     <= '0;
      ctrl_data_reg  <= '0;
      ctrl_valid_reg <= 1'b0;
    end else begin
      ctrl_valid_reg <= control_in_valid;
      if (control_in_valid) begin
        width_reg     <= control_in_data[35:20];
        height_reg    <= control_in_data[19:4];
        ctrl_data_reg <= control_in_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output position counters and frame_end. A new control word restarts the
  // frame and takes priority over a simultaneous output handshake, which is
  // then left uncounted. A zero width or height freezes the counters.
  // -------------------------------------------------------------------------
  logic [15:0] x_cnt_reg;
  logic [15:0] y_cnt_reg;
  logic        frame_end_reg;
  logic        out_hs;
  logic        size_ok;
  logic        x_last;
  logic        y_last;

  assign out_hs    = valid_pipe_reg[PIPE_STAGES-1] & video_out_ready;
  assign size_ok   = (width_reg != 16'd0) && (height_reg != 16'd0);
  assign x_last    = (x_cnt_reg == width_reg - 16'd1);
  assign y_last    = (y_cnt_reg == height_reg - 16'd1);
  assign frame_end = frame_end_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      frame_end_reg <= 1'b0;
    end else if (control_in_valid) begin
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      frame_end_reg <= 1'b0;
    end else if (out_hs && size_ok) begin
      frame_end_reg <= x_last && y_last;
      if (x_last) begin
        x_cnt_reg <= '0;
        y_cnt_reg <= y_last ? 16'd0 : y_cnt_reg + 16'd1;
      end else begin
        x_cnt_reg <= x_cnt_reg + 16'd1;
      end
    end else begin
      frame_end_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_ycbcr
//
// Self-checking bench for rgb_to_ycbcr. Inputs are driven on the falling
// edge; outputs and handshakes are sampled 1 ns later, before the rising
// edge that commits them. Expected pixels are pushed into a queue when the
// input handshake occurs and popped when the output handshake occurs.
// Define RGB2YCC_BYPASS_EN to also exercise the bypass port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rgb_to_ycbcr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] video_in_data = '0;
  logic        video_in_valid = 1'b0;
  logic        video_in_ready;
  logic [23:0] video_out_data;
  logic        video_out_valid;
  logic        video_out_ready = 1'b1;
  logic [35:0] control_in_data = '0;
  logic        control_in_valid = 1'b0;
  logic [35:0] control_out_data;
  logic        control_out_valid;
  logic        frame_end;
  logic        bypass = 1'b0;

  rgb_to_ycbcr dut (
    .clk               (clk),
    .rst               (rst),
    .video_in_data     (video_in_data),
    .video_in_valid    (video_in_valid),
    .video_in_ready    (video_in_ready),
    .video_out_data    (video_out_data),
    .video_out_valid   (video_out_valid),
    .video_out_ready   (video_out_ready),
    .control_in_data   (control_in_data),
    .control_in_valid  (control_in_valid),
    .control_out_data  (control_out_data),
    .control_out_valid (control_out_valid),
    .frame_end         (frame_end)
`ifdef RGB2YCC_BYPASS_EN
    ,
    .bypass            (bypass)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        in_hs;
  logic        out_hs;
  logic [23:0] exp_q[$];
  int          cyc_q[$];

  // Reference conversion in plain integer arithmetic.
  function automatic logic [23:0] model(input logic [23:0] p);
    int r, g, b, y, cb, cr;
    r  = p[23:16];
    g  = p[15:8];
    b  = p[7:0];
    y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
    cb = ((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128;
    cr = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128;
    if (y  < 0) y  = 0;
    if (y  > 255) y  = 255;
    if (cb < 0) cb = 0;
    if (cb > 255) cb = 255;
    if (cr < 0) cr = 0;
    if (cr > 255) cr = 255;
    return {y[7:0], cb[7:0], cr[7:0]};
  endfunction

  // One clock of stimulus; afterwards in_hs/out_hs say which handshakes the
  // coming rising edge performs, and the DUT outputs are stable to sample.
  task automatic step(input logic r, input logic iv, input logic [23:0] id,
                      input logic byp, input logic ordy, input logic cv,
                      input logic [35:0] cd);
    @(negedge clk);
    rst              = r;
    video_in_valid   = iv;
    video_in_data    = id;
    bypass           = byp;
    video_out_ready  = ordy;
    control_in_valid = cv;
    control_in_data  = cd;
    #1;
    in_hs  = iv & video_in_ready & ~r;
    out_hs = video_out_valid & ordy & ~r;
    cyc++;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (video_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", video_out_valid);
    end
    checks++;
    if (control_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl_valid: got %b required 0", control_out_valid);
    end
    checks++;
    if (frame_end !== 1'b0) begin
      errors++; $display("FAIL reset_frame_end: got %b required 0", frame_end);
    end
    checks++;
    if (video_out_data !== 24'h0) begin
      errors++; $display("FAIL reset_out_data: got %h required 000000", video_out_data);
    end
    checks++;
    if (control_out_data !== 36'h0) begin
      errors++; $display("FAIL reset_ctrl_data: got %h required 0", control_out_data);
    end
    checks++;
    if (video_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", video_in_ready);
    end
    $display("[reset] done");
  endtask

  task automatic test_basic();
    logic [23:0] px [4];
    logic [23:0] ek [4];
    logic [23:0] e;
    int          n = 0;
    int          got = 0;
    int          c;
    px = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h0000FF};
    ek = '{24'hFF8080, 24'h008080, 24'h4D55FF, 24'h1DFF6B};
    for (int i = 0; i < 12; i++) begin
      step(1'b0, n < 4, px[n % 4], 1'b0, 1'b1, 1'b0, '0);
      if (in_hs) begin
        exp_q.push_back(ek[n]); cyc_q.push_back(cyc); n++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_extra: got %h required no pixel", video_out_data);
        end else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front(); got++;
          $display("[basic] out=%h exp=%h", video_out_data, e);
          if (video_out_data !== e) begin
            errors++; $display("FAIL basic_data: got %h required %h", video_out_data, e);
          end
          checks++;
          if (cyc - c != 3) begin
            errors++; $display("FAIL basic_latency: got %0d required 3", cyc - c);
          end
        end
      end
    end
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_count: got %0d required 4", got);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] cur = 24'($urandom);
    logic [23:0] e;
    logic        ordy;
    int          n = 0;
    int          got = 0;
    for (int i = 0; i < 30; i++) begin
      ordy = !(i >= 6 && i < 11);
      step(1'b0, n < 8, cur, 1'b0, ordy, 1'b0, '0);
      checks++;
      if (video_in_ready !== (ordy | ~video_out_valid)) begin
        errors++; $display("FAIL bp_in_ready: cycle %0d got %b required %b",
                           i, video_in_ready, ordy | ~video_out_valid);
      end
      if (in_hs) begin
        exp_q.push_back(model(cur)); n++; cur = 24'($urandom);
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got %h required no pixel", video_out_data);
        end else begin
          e = exp_q.pop_front(); got++;
          $display("[backpressure] out=%h exp=%h", video_out_data, e);
          if (video_out_data !== e) begin
            errors++; $display("FAIL bp_data: got %h required %h", video_out_data, e);
          end
        end
      end
    end
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d required 8", got);
    end
  endtask

  task automatic test_frame();
    logic [35:0] cw = {16'd4, 16'd2, 4'h5};
    logic [23:0] cur = 24'($urandom);
    logic [23:0] e;
    logic        fe_exp = 1'b0;
    int          n = 0;
    int          k = 0;
    int          fe_cnt = 0;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, cw);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (control_out_valid !== 1'b1 || control_out_data !== cw) begin
      errors++; $display("FAIL frame_ctrl_fwd: got %b/%h required 1/%h",
                         control_out_valid, control_out_data, cw);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (control_out_valid !== 1'b0) begin
      errors++; $display("FAIL frame_ctrl_pulse: got %b required 0", control_out_valid);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, n < 16, cur, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (frame_end !== fe_exp) begin
        errors++; $display("FAIL frame_end: cycle %0d got %b required %b", i, frame_end, fe_exp);
      end
      if (frame_end === 1'b1) fe_cnt++;
      fe_exp = 1'b0;
      if (in_hs) begin
        exp_q.push_back(model(cur)); n++; cur = 24'($urandom);
      end
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front(); k++;
        $display("[frame] out=%h exp=%h", video_out_data, e);
        checks++;
        if (video_out_data !== e) begin
          errors++; $display("FAIL frame_data: got %h required %h", video_out_data, e);
        end
        if (k % 8 == 0) fe_exp = 1'b1;
      end
    end
    checks++;
    if (fe_cnt != 2 || k != 16) begin
      errors++; $display("FAIL frame_pulses: got %0d pulses %0d pixels required 2 and 16", fe_cnt, k);
    end
  endtask

  task automatic test_ctrl_collision();
    logic [35:0] cw = {16'd4, 16'd2, 4'hA};
    logic [23:0] cur = 24'($urandom);
    logic [23:0] e;
    logic        fe_exp = 1'b0;
    int          n = 0;
    int          k = 0;
    int          fe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, n < 11, cur, 1'b0, 1'b1, i == 5, (i == 5) ? cw : 36'h0);
      checks++;
      if (frame_end !== fe_exp) begin
        errors++; $display("FAIL coll_frame_end: cycle %0d got %b required %b", i, frame_end, fe_exp);
      end
      if (frame_end === 1'b1) fe_cnt++;
      fe_exp = 1'b0;
      if (i == 5) begin
        checks++;
        if (out_hs !== 1'b1) begin
          errors++; $display("FAIL coll_align: got handshake %b required 1", out_hs);
        end
      end
      if (i == 6) begin
        checks++;
        if (control_out_valid !== 1'b1 || control_out_data !== cw) begin
          errors++; $display("FAIL coll_ctrl_fwd: got %b/%h required 1/%h",
                             control_out_valid, control_out_data, cw);
        end
      end
      if (in_hs) begin
        exp_q.push_back(model(cur)); n++; cur = 24'($urandom);
      end
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("[collision] out=%h exp=%h", video_out_data, e);
        checks++;
        if (video_out_data !== e) begin
          errors++; $display("FAIL coll_data: got %h required %h", video_out_data, e);
        end
        if (i == 5) begin
          k = 0;
        end else begin
          k++;
          if (k == 8) fe_exp = 1'b1;
        end
      end
    end
    checks++;
    if (fe_cnt != 1) begin
      errors++; $display("FAIL coll_pulses: got %0d required 1", fe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] cwa = {16'd4, 16'd2, 4'h0};
    logic [35:0] cwb = {16'd2, 16'd1, 4'h3};
    logic [23:0] cur = 24'($urandom);
    logic [23:0] e;
    logic        fe_exp = 1'b0;
    int          n = 0;
    int          k = 0;
    int          fe_cnt = 0;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, cwa);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, cwb);
    checks++;
    if (control_out_valid !== 1'b1 || control_out_data !== cwa) begin
      errors++; $display("FAIL b2b_first: got %b/%h required 1/%h",
                         control_out_valid, control_out_data, cwa);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (control_out_valid !== 1'b1 || control_out_data !== cwb) begin
      errors++; $display("FAIL b2b_second: got %b/%h required 1/%h",
                         control_out_valid, control_out_data, cwb);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, n < 4, cur, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (frame_end !== fe_exp) begin
        errors++; $display("FAIL b2b_frame_end: cycle %0d got %b required %b", i, frame_end, fe_exp);
      end
      if (frame_end === 1'b1) fe_cnt++;
      fe_exp = 1'b0;
      if (in_hs) begin
        exp_q.push_back(model(cur)); n++; cur = 24'($urandom);
      end
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front(); k++;
        $display("[back_to_back] out=%h exp=%h", video_out_data, e);
        checks++;
        if (video_out_data !== e) begin
          errors++; $display("FAIL b2b_data: got %h required %h", video_out_data, e);
        end
        if (k % 2 == 0) fe_exp = 1'b1;
      end
    end
    checks++;
    if (fe_cnt != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d required 2", fe_cnt);
    end
  endtask

`ifdef RGB2YCC_BYPASS_EN
  task automatic test_bypass();
    logic [23:0] px [3];
    logic [23:0] ek [3];
    logic [2:0]  bf = 3'b010;
    logic [23:0] e;
    int          n = 0;
    int          got = 0;
    int          c;
    px = '{24'hFF0000, 24'h123456, 24'h0000FF};
    ek = '{24'h4D55FF, 24'h123456, 24'h1DFF6B};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, n < 3, px[n % 3], (n < 3) ? bf[n % 3] : 1'b0, 1'b1, 1'b0, '0);
      if (in_hs) begin
        exp_q.push_back(ek[n]); cyc_q.push_back(cyc); n++;
      end
      if (out_hs && exp_q.size() != 0) begin
        e = exp_q.pop_front(); c = cyc_q.pop_front(); got++;
        $display("[bypass] out=%h exp=%h", video_out_data, e);
        checks++;
        if (video_out_data !== e || cyc - c != 3) begin
          errors++; $display("FAIL bypass_data: got %h after %0d required %h after 3",
                             video_out_data, cyc - c, e);
        end
      end
    end
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL bypass_count: got %0d required 3", got);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    logic [23:0] cur = 24'($urandom);
    logic [23:0] e;
    int          n = 0;
    int          got = 0;
    int          stale = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, cur, 1'b0, 1'b1, 1'b0, '0);
      cur = 24'($urandom);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    cyc_q.delete();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (video_out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %b required 0", video_out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      if (video_out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midrst_stale: got %0d stale cycles required 0", stale);
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, n < 6, cur, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (frame_end !== 1'b0) begin
        errors++; $display("FAIL midrst_frame_end: cycle %0d got %b required 0", i, frame_end);
      end
      if (in_hs) begin
        exp_q.push_back(model(cur)); n++; cur = 24'($urandom);
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL midrst_extra: got %h required no pixel", video_out_data);
        end else begin
          e = exp_q.pop_front(); got++;
          $display("[reset_midflight] out=%h exp=%h", video_out_data, e);
          if (video_out_data !== e) begin
            errors++; $display("FAIL midrst_data: got %h required %h", video_out_data, e);
          end
        end
      end
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL midrst_count: got %0d required 6", got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame();
    test_ctrl_collision();
    test_back_to_back();
`ifdef RGB2YCC_BYPASS_EN
    test_bypass();
`endif
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
